fetch_request_unit: RTL and testbench
=====================================

Name: fetch_request_unit

Overview:
- Sequences instruction fetch and data access against the instruction/data cache ports for the single-cycle core.
- Sits directly downstream of the PC.
  - Consumes the PC's imemaddr.
  - Returns ramfull, the hold signal that freezes the PC until the current instruction retires.
- Latches the fetched instruction and load data so decode/writeback see stable values while the caches settle.

Parameters:
- WORD_W, 32, width of addresses, instructions and data.
- STAT_W, 16, width of the optional stall counters.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous, active-high reset
- imemaddr  in  WORD_W  fetch address from PC
- iaddr  out  WORD_W  address to icache; combinational passthrough of imemaddr
- imemREN  out  1  icache read enable
- ihit  in  1  icache hit; iload valid
- iload  in  WORD_W  instruction from icache
- instr  out  WORD_W  latched instruction
- instr_valid  out  1  one-cycle pulse: instr is new
- dren_req  in  1  control: current instr is a load (sampled in EXEC)
- dwen_req  in  1  control: current instr is a store (sampled in EXEC)
- halt  in  1  control: current instr is halt (sampled in EXEC)
- dmemaddr_in  in  WORD_W  ALU address
- dmemstore_in  in  WORD_W  store data
- dmemREN  out  1  dcache read enable
- dmemWEN  out  1  dcache write enable
- dmemaddr  out  WORD_W  latched data address
- dmemstore  out  WORD_W  latched store data
- dhit  in  1  dcache hit
- dload  in  WORD_W  dcache read data
- dload_q  out  WORD_W  latched load data
- ramfull  out  1  1 = PC holds; 0 = PC advances this edge
- halted  out  1  core halted (sticky)

Behaviour:
- States: FETCH, EXEC, DATA, HALT. State register updates on posedge CLK only.
- Reset (RST=1 at edge):
  - State goes to FETCH.
  - instr=0, instr_valid=0, dmemaddr=0, dmemstore=0, dload_q=0, halted=0.
  - While RST is high, ramfull=1 and imemREN=dmemREN=dmemWEN=0, combinationally forced.
  - Reset mid-DATA drops REN/WEN in the same cycle RST is seen; no partial retire.
- FETCH:
  - imemREN=1, ramfull=1.
  - On ihit: instr<=iload, go to EXEC.
  - Without ihit: stay in FETCH indefinitely.
- EXEC:
  - instr_valid=1, imemREN=0.
  - Priority: halt > data request > retire.
  - halt=1: go to HALT, ramfull=1.
  - dren_req or dwen_req: dmemaddr<=dmemaddr_in, dmemstore<=dmemstore_in, go to DATA, ramfull=1.
  - Otherwise: ramfull=0 (PC advances this edge), go to FETCH.
- DATA:
  - dmemWEN = latched write flag; dmemREN = latched read flag.
  - If dren_req and dwen_req are both set in EXEC, the write wins: dmemWEN=1, dmemREN=0.
  - On dhit: ramfull=0, go to FETCH. If the access is a read, also dload_q<=dload.
  - Without dhit: ramfull=1, hold all outputs stable.
- HALT: halted=1, ramfull=1, all enables 0. Exit only via RST.
- Stray hits: ihit outside FETCH and dhit outside DATA are ignored.
- Latency:
  - Non-memory instr: ihit edge + 1 cycle EXEC, i.e. ramfull=0 exactly 1 cycle after the ihit cycle.
  - Memory instr: adds the DATA wait cycles plus the dhit cycle.
  - ramfull=0 lasts exactly one cycle per retired instruction.
- Widths: all data paths WORD_W; no arithmetic on addresses (the PC owns increment).

Optional Feature:
- Macro: FETCH_REQUEST_STATS_EN.
- Defined, the block adds three outputs: istall_cnt, dstall_cnt, retire_cnt, each STAT_W bits.
  - istall_cnt increments on each FETCH cycle without ihit.
  - dstall_cnt increments on each DATA cycle without dhit.
  - retire_cnt increments on each ramfull=0 cycle.
  - All three saturate at all-ones (no wrap), clear on RST, and freeze in HALT.
- Undefined: the ports and counters are absent; core behaviour is identical.

Test Plan:
1. RST=1 for 2 cycles, imemaddr=0x0 -> ramfull=1, imemREN=0 during reset. Next cycle after release: imemREN=1, state FETCH, halted=0.
2. ihit=1 with iload=0x24020005 (addiu), no data requests -> next cycle: instr=0x24020005, instr_valid=1, ramfull=0. Following cycle: back in FETCH with imemREN=1.
3. Load: iload=0x8C430004, dren_req=1, dmemaddr_in=0x100; dhit after 3 wait cycles with dload=0xDEADBEEF -> dmemREN=1 for 4 cycles, dmemaddr=0x100 stable throughout, dload_q=0xDEADBEEF, single ramfull=0 pulse.
4. Store with dren_req=dwen_req=1, dmemstore_in=0x12345678 -> dmemWEN=1, dmemREN=0, dmemstore=0x12345678 until dhit.
5. halt=1 in EXEC, with spurious ihit/dhit afterwards -> halted=1, ramfull=1, enables 0 for 20 cycles; RST then returns the block to FETCH with halted=0.
6. RST asserted on the 2nd DATA wait cycle -> dmemREN drops that cycle, dload_q=0, no ramfull=0 pulse. With FETCH_REQUEST_STATS_EN defined: dstall_cnt=0 after reset, and 5 istall cycles give istall_cnt=5.

Source files
------------

// File: rtl/fetch_request_unit.sv
// Fetch/data sequencer for the single-cycle core: walks FETCH -> EXEC -> (DATA) and holds the PC via ramfull.
// Optional stall/retire counters are built when FETCH_REQUEST_STATS_EN is defined.
module fetch_request_unit #(
    parameter int WORD_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] iaddr,
    output logic              imemREN,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              dren_req,
    input  logic              dwen_req,
    input  logic              halt,
    input  logic [WORD_W-1:0] dmemaddr_in,
    input  logic [WORD_W-1:0] dmemstore_in,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    output logic [WORD_W-1:0] dload_q,
    output logic              ramfull,
    output logic              halted
`ifdef FETCH_REQUEST_STATS_EN
    ,
    output logic [STAT_W-1:0] istall_cnt,
    output logic [STAT_W-1:0] dstall_cnt,
    output logic [STAT_W-1:0] retire_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DATA  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state, state_next;
    logic   rd_q, wr_q;
    logic   data_req;

    assign iaddr    = imemaddr;
    assign data_req = dren_req | dwen_req;

    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (ihit) state_next = EXEC;
            EXEC: begin
                if (halt)          state_next = HALT;
                else if (data_req) state_next = DATA;
                else               state_next = FETCH;
            end
            DATA:  if (dhit) state_next = FETCH;
            HALT:  state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Reset overrides the enables and the hold combinationally so a
    // reset seen mid-access drops the request in that very cycle.
    always_comb begin
        imemREN     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        ramfull     = 1'b1;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH: imemREN = 1'b1;
            EXEC: begin
                instr_valid = 1'b1;
                if (!halt && !data_req) ramfull = 1'b0;
            end
            DATA: begin
                dmemWEN = wr_q;
                dmemREN = rd_q;
                if (dhit) ramfull = 1'b0;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
        if (RST) begin
            imemREN = 1'b0;
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
            ramfull = 1'b1;
        end
    end

    // A store-and-load request is treated as a store; rd_q and wr_q are
    // therefore never both set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr     <= '0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            dload_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            case (state)
                FETCH: if (ihit) instr <= iload;
                EXEC: begin
                    if (!halt && data_req) begin
                        dmemaddr  <= dmemaddr_in;
                        dmemstore <= dmemstore_in;
                        rd_q      <= dren_req & ~dwen_req;
                        wr_q      <= dwen_req;
                    end
                end
                DATA: if (dhit && rd_q) dload_q <= dload;
                default: ;
            endcase
        end
    end

`ifdef FETCH_REQUEST_STATS_EN
    logic istall_inc, dstall_inc, retire_inc;

    assign istall_inc = (state == FETCH) && !ihit;
    assign dstall_inc = (state == DATA) && !dhit;
    assign retire_inc = !ramfull;

    // Counters saturate; HALT never satisfies any increment, so they freeze there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            istall_cnt <= '0;
            dstall_cnt <= '0;
            retire_cnt <= '0;
        end else begin
            if (istall_inc && istall_cnt != '1) istall_cnt <= istall_cnt + 1'b1;
            if (dstall_inc && dstall_cnt != '1) dstall_cnt <= dstall_cnt + 1'b1;
            if (retire_inc && retire_cnt != '1) retire_cnt <= retire_cnt + 1'b1;
        end
    end
`else
    logic [STAT_W-1:0] stat_unused;
    assign stat_unused = '0;
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Randomized instruction-level bench for fetch_request_unit: each instruction is a
// (kind, fetch waits, data waits) transaction and outputs are predicted per phase.
module tb_fetch_request_unit;
    localparam int W = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  imemaddr, iaddr, iload, instr;
    logic [W-1:0]  dmemaddr_in, dmemstore_in, dmemaddr, dmemstore, dload, dload_q;
    logic          imemREN, ihit, instr_valid, dren_req, dwen_req, halt;
    logic          dmemREN, dmemWEN, dhit, ramfull, halted;
`ifdef FETCH_REQUEST_STATS_EN
    logic [SW-1:0] istall_cnt, dstall_cnt, retire_cnt;
`endif

    fetch_request_unit #(.WORD_W(W), .STAT_W(SW)) dut (
        .CLK(clk), .RST(rst), .imemaddr(imemaddr), .iaddr(iaddr), .imemREN(imemREN),
        .ihit(ihit), .iload(iload), .instr(instr), .instr_valid(instr_valid),
        .dren_req(dren_req), .dwen_req(dwen_req), .halt(halt),
        .dmemaddr_in(dmemaddr_in), .dmemstore_in(dmemstore_in),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dload(dload), .dload_q(dload_q), .ramfull(ramfull), .halted(halted)
`ifdef FETCH_REQUEST_STATS_EN
        , .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt), .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [W-1:0] e_instr, e_daddr, e_dstore, e_dq;
    int e_is, e_ds, e_rt;

    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BOTH = 3, K_HALT = 4;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] sat(input int v);
        return (v > (1 << SW) - 1) ? W'((1 << SW) - 1) : W'(v);
    endfunction

    task automatic chk_regs();
        chk("iaddr", iaddr, imemaddr);
        chk("instr", instr, e_instr);
        chk("dmemaddr", dmemaddr, e_daddr);
        chk("dmemstore", dmemstore, e_dstore);
        chk("dload_q", dload_q, e_dq);
`ifdef FETCH_REQUEST_STATS_EN
        chk("istall_cnt", W'(istall_cnt), sat(e_is));
        chk("dstall_cnt", W'(dstall_cnt), sat(e_ds));
        chk("retire_cnt", W'(retire_cnt), sat(e_rt));
`endif
    endtask

    task automatic junk();
        imemaddr     = $urandom;
        iload        = $urandom;
        ihit         = 1'($urandom_range(0, 1));
        dhit         = 1'($urandom_range(0, 1));
        dren_req     = 1'($urandom_range(0, 1));
        dwen_req     = 1'($urandom_range(0, 1));
        halt         = 1'($urandom_range(0, 1));
        dmemaddr_in  = $urandom;
        dmemstore_in = $urandom;
        dload        = $urandom;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            junk();
            rst = 1'b1;
            #1;
            chk("rst_ramfull", W'(ramfull), 1);
            chk("rst_imemREN", W'(imemREN), 0);
            chk("rst_dmemREN", W'(dmemREN), 0);
            chk("rst_dmemWEN", W'(dmemWEN), 0);
            @(negedge clk);
        end
        rst = 1'b0;
        e_instr = '0; e_daddr = '0; e_dstore = '0; e_dq = '0;
        e_is = 0; e_ds = 0; e_rt = 0;
    endtask

    task automatic chk_fetch();
        chk("f_imemREN", W'(imemREN), 1);
        chk("f_ramfull", W'(ramfull), 1);
        chk("f_valid", W'(instr_valid), 0);
        chk("f_dmemREN", W'(dmemREN), 0);
        chk("f_dmemWEN", W'(dmemWEN), 0);
        chk("f_halted", W'(halted), 0);
        chk_regs();
    endtask

    task automatic fetch_phase(input int fw, input logic [W-1:0] iv);
        for (int i = 0; i < fw; i++) begin
            junk(); ihit = 1'b0;
            #1; chk_fetch();
            e_is++;
            @(negedge clk);
        end
        junk(); ihit = 1'b1; iload = iv;
        #1; chk_fetch();
        @(negedge clk);
        e_instr = iv;
    endtask

    task automatic exec_phase(input int kind, input logic [W-1:0] a, input logic [W-1:0] s);
        junk();
        halt     = (kind == K_HALT);
        dren_req = (kind == K_LD) || (kind == K_BOTH);
        dwen_req = (kind == K_ST) || (kind == K_BOTH);
        dmemaddr_in = a; dmemstore_in = s;
        #1;
        chk("e_valid", W'(instr_valid), 1);
        chk("e_imemREN", W'(imemREN), 0);
        chk("e_ramfull", W'(ramfull), (kind == K_ALU) ? 1'b0 : 1'b1);
        chk_regs();
        if (kind == K_ALU) e_rt++;
        @(negedge clk);
        if (kind >= K_LD && kind <= K_BOTH) begin
            e_daddr = a; e_dstore = s;
        end
    endtask

    task automatic chk_data(input int kind, input logic hit);
        chk("d_dmemREN", W'(dmemREN), (kind == K_LD) ? 1'b1 : 1'b0);
        chk("d_dmemWEN", W'(dmemWEN), (kind == K_LD) ? 1'b0 : 1'b1);
        chk("d_ramfull", W'(ramfull), hit ? 1'b0 : 1'b1);
        chk("d_imemREN", W'(imemREN), 0);
        chk("d_valid", W'(instr_valid), 0);
        chk_regs();
    endtask

    task automatic data_phase(input int kind, input int dw, input logic [W-1:0] d);
        for (int i = 0; i < dw; i++) begin
            junk(); dhit = 1'b0;
            #1; chk_data(kind, 1'b0);
            e_ds++;
            @(negedge clk);
        end
        junk(); dhit = 1'b1; dload = d;
        #1; chk_data(kind, 1'b1);
        e_rt++;
        @(negedge clk);
        if (kind == K_LD) e_dq = d;
    endtask

    task automatic halt_phase(input int n);
        for (int i = 0; i < n; i++) begin
            junk();
            #1;
            chk("h_halted", W'(halted), 1);
            chk("h_ramfull", W'(ramfull), 1);
            chk("h_imemREN", W'(imemREN), 0);
            chk("h_dmemREN", W'(dmemREN), 0);
            chk("h_dmemWEN", W'(dmemWEN), 0);
            chk_regs();
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input int kind, input int fw, input int dw, input logic [W-1:0] iv,
                             input logic [W-1:0] a, input logic [W-1:0] s, input logic [W-1:0] d);
        fetch_phase(fw, iv);
        exec_phase(kind, a, s);
        if (kind >= K_LD && kind <= K_BOTH) data_phase(kind, dw, d);
        if (kind == K_HALT) begin
            halt_phase(20);
            do_reset(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        junk();
        do_reset(2);

        run_instr(K_ALU, 0, 0, 32'h24020005, 32'h0, 32'h0, 32'h0);
        run_instr(K_LD, 1, 3, 32'h8C430004, 32'h100, $urandom, 32'hDEADBEEF);
        run_instr(K_BOTH, 0, 2, 32'hAC430008, 32'h200, 32'h12345678, $urandom);
        run_instr(K_ST, 2, 0, $urandom, $urandom, $urandom, $urandom);
        run_instr(K_HALT, 0, 0, 32'h0000000C, 32'h0, 32'h0, 32'h0);

        // reset arriving on the second DATA wait cycle of a load
        fetch_phase(0, 32'h8C440010);
        exec_phase(K_LD, 32'h300, $urandom);
        junk(); dhit = 1'b0;
        #1; chk_data(K_LD, 1'b0);
        e_ds++;
        @(negedge clk);
        junk(); dhit = 1'b0; rst = 1'b1;
        #1;
        chk("abort_dmemREN", W'(dmemREN), 0);
        chk("abort_ramfull", W'(ramfull), 1);
        @(negedge clk);
        do_reset(1);
        run_instr(K_ALU, 5, 0, $urandom, $urandom, $urandom, $urandom);

        for (int n = 0; n < 300; n++) begin
            int r, kind;
            r = $urandom_range(0, 19);
            kind = (r < 8) ? K_ALU : (r < 12) ? K_LD : (r < 16) ? K_ST : (r < 19) ? K_BOTH : K_HALT;
            run_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, $urandom, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
